// File: rtl/conv_relu_pool.sv
// Post-MAC stage: tracks sum validity through the multiply-adder latency, requantizes with
// rounding/saturation/ReLU, then applies 2x2 stride-2 max pooling over a raster feature map.
module conv_relu_pool #(
    parameter int ADD_WIDTH    = 24,
    parameter int OUT_WIDTH    = 9,
    parameter int PIPE_LATENCY = 7,
    parameter int SHIFT        = 8,
    parameter int FM_WIDTH     = 8,
    parameter int FM_HEIGHT    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 flush,
    input  logic [ADD_WIDTH-1:0] sum_in,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 frame_done
);

    localparam int RW = OUT_WIDTH - 1;
    localparam int CW = $clog2(FM_WIDTH);
    localparam int HW = $clog2(FM_HEIGHT);
    localparam int LB = FM_WIDTH / 2;
    localparam int LW = (LB > 1) ? $clog2(LB) : 1;

    localparam logic signed [ADD_WIDTH:0] RND  = (ADD_WIDTH + 1)'(1) << (SHIFT - 1);
    localparam logic signed [ADD_WIDTH:0] QMAX = (ADD_WIDTH + 1)'((1 << RW) - 1);

    logic [PIPE_LATENCY-1:0] vpipe;
    logic                    sum_valid;
    logic signed [ADD_WIDTH:0] t;
    logic signed [ADD_WIDTH:0] q;
    logic [RW-1:0]           r;
    logic                    a_v;
    logic [RW-1:0]           a_r;

    assign sum_valid = vpipe[PIPE_LATENCY-1];

    // One extra bit of headroom so the rounding offset can never overflow.
    always_comb begin
        t = $signed({sum_in[ADD_WIDTH-1], sum_in}) + RND;
        q = t >>> SHIFT;
        if (q[ADD_WIDTH]) begin
            r = '0;
        end else if (q > QMAX) begin
            r = '1;
        end else begin
            r = q[RW-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vpipe <= '0;
            a_v   <= 1'b0;
            a_r   <= '0;
        end else if (flush) begin
            vpipe <= '0;
            a_v   <= 1'b0;
        end else begin
            vpipe <= (vpipe << 1) | PIPE_LATENCY'(in_valid);
            a_v   <= sum_valid;
            if (sum_valid) begin
                a_r <= r;
            end
        end
    end

    logic [CW-1:0] col;
    logic [HW-1:0] row;
    logic [RW-1:0] hold;
    logic [RW-1:0] linebuf [LB];
    logic [LW-1:0] lb_idx;
    logic [RW-1:0] lb_rd;
    logic [RW-1:0] hm;
    logic [RW-1:0] pm;
    logic          col_last;
    logic          row_last;

    always_comb begin
        lb_idx   = LW'(col >> 1);
        lb_rd    = linebuf[lb_idx];
        hm       = (a_r > hold) ? a_r : hold;
        pm       = (lb_rd > hm) ? lb_rd : hm;
        col_last = (col == CW'(FM_WIDTH - 1));
        row_last = (row == HW'(FM_HEIGHT - 1));
    end

    // Even rows always write a slot before the following odd row reads it, so no reset needed.
    always_ff @(posedge clock) begin
        if (a_v && !flush && col[0] && !row[0]) begin
            linebuf[lb_idx] <= hm;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col        <= '0;
            row        <= '0;
            hold       <= '0;
            out        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else if (flush) begin
            col        <= '0;
            row        <= '0;
            hold       <= '0;
            out        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (a_v) begin
                if (!col[0]) begin
                    hold <= a_r;
                end else if (row[0]) begin
                    out        <= {1'b0, pm};
                    out_valid  <= 1'b1;
                    frame_done <= col_last && row_last;
                end
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_relu_pool.sv
// Randomized and directed bench for conv_relu_pool; an arithmetic reference model feeds a
// scoreboard queue that a free-running monitor drains whenever out_valid pulses.
module tb_conv_relu_pool;

    localparam int AW = 24;
    localparam int OW = 9;
    localparam int PL = 7;
    localparam int SH = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] sum_in = '0;
    logic          out_valid;
    logic [OW-1:0] out;
    logic          frame_done;

    always #5 clock = ~clock;

    conv_relu_pool #(
        .ADD_WIDTH(AW), .OUT_WIDTH(OW), .PIPE_LATENCY(PL),
        .SHIFT(SH), .FM_WIDTH(W), .FM_HEIGHT(H)
    ) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .flush(flush),
        .sum_in(sum_in), .out_valid(out_valid), .out(out), .frame_done(frame_done)
    );

    typedef struct { int val; bit fd; int at; } exp_t;

    int            cyc = 0;
    int            n_vec = 0;
    int            n_err = 0;
    int            p = 0;
    int            hold_exp = 0;
    int            img [H][W];
    exp_t          exp_q [$];
    logic [AW-1:0] sched [int];

    int pool_r [16] = '{1, 5, 2, 3, 4, 0, 9, 7, 8, 8, 0, 1, 2, 200, 6, 0};
    logic [AW-1:0] frame_a [16] = '{
        24'h000180, 24'h000000, 24'h000000, 24'h00017F,
        24'h000000, 24'h000000, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h00007F, 24'h000000,
        24'h000080, 24'h000000, 24'h000000, 24'h000000};
    logic [AW-1:0] frame_b [16] = '{
        24'h000000, 24'h000000, 24'h010000, 24'h000000,
        24'h000000, 24'h7FFFFF, 24'h000000, 24'h000000,
        24'hFFFFFF, 24'hFFFF00, 24'hFFF000, 24'hFFF000,
        24'hFFFFFF, 24'hFFFFFF, 24'hFFF000, 24'h800000};

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Round half up, floor-divide by 2^SH, clamp to [0, 2^(OW-1)-1].
    function automatic int requant(input logic [AW-1:0] s);
        int v;
        int q;
        v = int'($signed(s));
        q = (v + (1 << (SH - 1))) >>> SH;
        if (q < 0) q = 0;
        if (q > (1 << (OW - 1)) - 1) q = (1 << (OW - 1)) - 1;
        return q;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic void model_pixel(input logic [AW-1:0] s, input int c);
        int rr;
        int cc;
        int m;
        rr = p / W;
        cc = p % W;
        img[rr][cc] = requant(s);
        if (rr % 2 == 1 && cc % 2 == 1) begin
            m = max2(max2(img[rr-1][cc-1], img[rr-1][cc]), max2(img[rr][cc-1], img[rr][cc]));
            exp_q.push_back('{m, (p == W * H - 1), c + PL + 2});
        end
        p = (p + 1) % (W * H);
    endfunction

    task automatic drive_sum();
        sum_in = sched.exists(cyc) ? sched[cyc] : AW'($urandom);
    endtask

    task automatic step(input bit v, input logic [AW-1:0] s);
        @(negedge clock);
        flush = 1'b0;
        in_valid = v;
        if (v) begin
            sched[cyc + PL] = s;
            model_pixel(s, cyc);
        end
        drive_sum();
    endtask

    task automatic flush_step(input logic [AW-1:0] s);
        @(negedge clock);
        flush = 1'b1;
        in_valid = 1'b1;
        sched[cyc + PL] = s;
        p = 0;
        drive_sum();
    endtask

    task automatic do_reset();
        @(negedge clock);
        in_valid = 1'b0;
        flush = 1'b0;
        drive_sum();
        #2 reset = 1'b0;
        p = 0;
        @(negedge clock);
        drive_sum();
        @(negedge clock);
        drive_sum();
        #2 reset = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < PL + 6; i++) step(1'b0, '0);
        check("outputs outstanding", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic send_pool(input int gap_every, input int gap_at);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, AW'(pool_r[i] << 8));
            if (gap_every != 0) step(1'b0, '0);
            if (i == gap_at) for (int k = 0; k < 5; k++) step(1'b0, '0);
        end
    endtask

    always begin
        exp_t e;
        @(posedge clock);
        #1;
        if (!reset || flush) hold_exp = 0;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("stray out_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("pooled value", out, e.val);
                check("frame_done", frame_done, e.fd);
                check("latency cycle", cyc, e.at);
                hold_exp = e.val;
            end
        end else begin
            check("frame_done without out_valid", frame_done, 0);
            check("out hold", out, hold_exp);
        end
    end

    initial begin
        repeat (3) @(negedge clock);
        check("reset out", out, 0);
        check("reset out_valid", out_valid, 0);
        check("reset frame_done", frame_done, 0);
        @(negedge clock);
        reset = 1'b1;

        // Contiguous pooling stream.
        send_pool(0, -1);
        drain();

        // Alternate bubbles plus a 5-cycle gap mid-row 1.
        send_pool(1, 5);
        drain();

        // Abandon a partial frame with reset.
        for (int i = 0; i < 3; i++) step(1'b1, AW'(pool_r[i] << 8));
        do_reset();
        check("out after reset", out, 0);
        send_pool(0, -1);
        drain();

        // Same with flush, with in_valid high during the flush cycle.
        for (int i = 0; i < 3; i++) step(1'b1, AW'(pool_r[i] << 8));
        flush_step(24'h00FF00);
        send_pool(0, -1);
        drain();

        // Rounding then saturation/ReLU frames, back to back.
        for (int i = 0; i < 16; i++) step(1'b1, frame_a[i]);
        for (int i = 0; i < 16; i++) step(1'b1, frame_b[i]);
        drain();

        // Random frames with random bubbles.
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < W * H; i++) begin
                logic [AW-1:0] s;
                if ($urandom_range(0, 3) == 0) s = AW'($urandom);
                else s = AW'(int'($urandom_range(0, 300) << 8) + int'($urandom_range(0, 255)) - 128);
                while ($urandom_range(0, 2) == 0) step(1'b0, '0);
                step(1'b1, s);
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
